pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core. Sits beside the decode stage and generates the global 6-bit stall vector.
- Holds the pipeline while a multi-cycle execute op (e.g. iterative shift/mul) occupies the execute stage.
- Keeps a register scoreboard so that decode stalls on RAW/WAW hazards against pending multi-cycle results. Those results are not forwarded from ex/mem, only written back.
- Handles pipeline flush.

Parameters:
NUM_REGS, 32, architectural register count (scoreboard depth; equals 2^`RegAddrBus width)
MC_LEN_W, 4, width of the multi-cycle latency field from decode

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset; compared against `RstEnable
id_valid_i  input  1  decode holds a valid instruction
id_reg1_read_i  input  1  decode reads source 1
id_reg1_addr_i  input  `RegAddrBus  source 1 address
id_reg2_read_i  input  1  decode reads source 2
id_reg2_addr_i  input  `RegAddrBus  source 2 address
id_wreg_i  input  1  decode instruction writes a register
id_wd_i  input  `RegAddrBus  destination address
id_mc_i  input  1  decode instruction is multi-cycle in ex
id_mc_len_i  input  MC_LEN_W  total ex cycles for the multi-cycle op
wb_wreg_i  input  1  writeback writes the regfile this cycle
wb_wd_i  input  `RegAddrBus  writeback destination
flush_i  input  1  kill all in-flight work
stall_o  output  6  {wb,mem,ex,id,if,pc} hold bits, bit0=pc
ex_done_o  output  1  final ex cycle of a multi-cycle op
flush_o  output  1  flush to stage registers
sb_busy_o  output  NUM_REGS  scoreboard (debug/verification visibility)

Behaviour:
- Reset (rst==`RstEnable at posedge):
  - state=IDLE, counter=0, scoreboard=0.
  - Combinational outputs forced while rst is high: stall_o=6'b000000, ex_done_o=0, flush_o=0.
- Effective latency L = (id_mc_len_i<2) ? 2 : id_mc_len_i. The op sits in ex for exactly L cycles.
- hazard (combinational), true if any of:
  - id_reg1_read_i & busy[reg1]
  - id_reg2_read_i & busy[reg2]
  - id_wreg_i & busy[id_wd_i]
  - Exception: a bit being cleared by writeback this cycle does not count (regfile is write-through). Register 0 is never busy.
- issue = id_valid_i & id_mc_i & ~hazard & ~flush_i & state∈{IDLE,LAST}.
- FSM states:
  - IDLE:
    - stall_o = hazard ? 6'b000111 : 0. Decode holds and a bubble enters ex.
    - On issue: go to EXEC, counter=L-1.
  - EXEC:
    - stall_o=6'b001111; no issue possible.
    - counter decrements each cycle.
    - When counter==1: go to LAST.
  - LAST:
    - ex_done_o=1; no stall from the FSM; hazard stall as in IDLE.
    - On issue: go to EXEC with the new counter; otherwise go to IDLE.
- Stall priority: rst > flush_i (0) > EXEC (001111) > hazard (000111) > 0.
- Scoreboard:
  - Set: on issue edge, if id_wreg_i and id_wd_i!=0, set busy[id_wd_i].
  - Clear: on wb_wreg_i edge, clear busy[wb_wd_i].
  - Set and clear on the same register in the same cycle: set wins.
- Flush:
  - flush_o=flush_i (same cycle, gated by rst).
  - Next edge: state=IDLE, counter=0, whole scoreboard cleared. A writeback in the flush cycle is irrelevant.
  - Flush overrides a simultaneous issue.
- Non-multi-cycle instructions never touch the FSM or the scoreboard.

Decomposition:
- Shared defines file gets:
  - state encodings `PHC_IDLE/`PHC_EXEC/`PHC_LAST
  - stall patterns `StallNone=6'b000000, `StallId=6'b000111, `StallEx=6'b001111
  - `MinMcLen=2
- One natural sub-module: mc_scoreboard. It holds the busy vector with set/clear/clear-all and exposes the combinational hazard lookup. The FSM and stall mux stay in pipe_hazard_ctrl.

Test Plan:
- rst=1 for 2 cycles with random inputs -> stall_o=0, ex_done_o=0, sb_busy_o=0; after release, state IDLE.
- Issue mc op len=4, wd=r3 -> stall_o=001111 for 3 cycles, then ex_done_o=1 for 1 cycle with stall_o=0; busy[3]=1 until wb_wreg_i=1, wb_wd_i=3, then 0 on the next cycle.
- Follow-up instruction reads r3 while busy -> stall_o=000111 every cycle until the writeback cycle; in the writeback cycle hazard=0 and stall_o=0.
- id_mc_len_i=0 and then 1 -> each treated as L=2: exactly one 001111 cycle, then ex_done_o.
- flush_i=1 in 2nd EXEC cycle with busy[5]=1 -> flush_o=1 that cycle, stall_o=0; next cycle IDLE, sb_busy_o=0.
- Mc op with wd=r0 -> no busy bit set. Issue to r7 in the same cycle wb clears r7 -> busy[7] stays 1. Back-to-back issue from LAST -> re-enters EXEC without an IDLE cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
// Register address width, reset level, FSM state encoding and the stall
// patterns driven onto the global {wb,mem,ex,id,if,pc} hold vector.

package pipe_hazard_ctrl_pkg;

  // Architectural register address width (32 registers)
  localparam int REG_ADDR_W = 5;

  // Level of rst that means "in reset"
  localparam logic RST_ENABLE = 1'b1;

  // Shortest multi-cycle execute occupancy; shorter requests are stretched
  localparam int MIN_MC_LEN = 2;

  // Stall vector patterns, bit0 = pc, bit5 = wb
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

  // Multi-cycle execute sequencing states
  typedef enum logic [1:0] {
    PHC_IDLE = 2'd0,
    PHC_EXEC = 2'd1,
    PHC_LAST = 2'd2
  } phc_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// Register scoreboard for results of multi-cycle execute ops.
// A bit is set when such an op issues with a destination register and is
// cleared when writeback retires that register. The hazard lookup treats
// a bit being retired this very cycle as free, because the regfile is
// write-through. Register 0 is never reported busy.

module mc_scoreboard
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic                  clr_all,
  input  logic                  rd1_en,
  input  logic [REG_ADDR_W-1:0] rd1_addr,
  input  logic                  rd2_en,
  input  logic [REG_ADDR_W-1:0] rd2_addr,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  output logic                  hazard,
  output logic [NUM_REGS-1:0]   busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_eff;
  logic [NUM_REGS-1:0] busy_next;

  // Busy view seen by decode: writeback retiring a register this cycle frees it
  always_comb begin
    busy_eff = busy_q;
    if (clr_en) begin
      busy_eff[clr_addr] = 1'b0;
    end
    busy_eff[0] = 1'b0;
  end

  // RAW on either source or WAW on the destination against a pending result
  always_comb begin
    hazard = (rd1_en & busy_eff[rd1_addr]) |
             (rd2_en & busy_eff[rd2_addr]) |
             (wr_en  & busy_eff[wr_addr]);
  end

  // Next busy vector: clear first so that a same-register set overrides it
  always_comb begin
    busy_next = busy_q;
    if (clr_en) begin
      busy_next[clr_addr] = 1'b0;
    end
    if (set_en) begin
      busy_next[set_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Scoreboard state, wiped by reset or by a pipeline flush
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      busy_q <= '0;
    end else if (clr_all) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_next;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller beside decode. Holds the pipeline while a
// multi-cycle op occupies execute, stalls decode on hazards against pending
// multi-cycle results (they are only written back, never forwarded), and
// turns flush requests into a same-cycle flush plus a state wipe.

module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int MC_LEN_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid_i,
  input  logic                  id_reg1_read_i,
  input  logic [REG_ADDR_W-1:0] id_reg1_addr_i,
  input  logic                  id_reg2_read_i,
  input  logic [REG_ADDR_W-1:0] id_reg2_addr_i,
  input  logic                  id_wreg_i,
  input  logic [REG_ADDR_W-1:0] id_wd_i,
  input  logic                  id_mc_i,
  input  logic [MC_LEN_W-1:0]   id_mc_len_i,
  input  logic                  wb_wreg_i,
  input  logic [REG_ADDR_W-1:0] wb_wd_i,
  input  logic                  flush_i,
  output logic [5:0]            stall_o,
  output logic                  ex_done_o,
  output logic                  flush_o,
  output logic [NUM_REGS-1:0]   sb_busy_o
);

  localparam logic [MC_LEN_W-1:0] MIN_LEN = MC_LEN_W'(MIN_MC_LEN);
  localparam logic [MC_LEN_W-1:0] ONE     = MC_LEN_W'(1);

  phc_state_e          state_q;
  logic [MC_LEN_W-1:0] count_q;
  logic                ex_done_q;
  logic [MC_LEN_W-1:0] eff_len;
  logic                hazard;
  logic                issue_window;
  logic                issue;
  logic                sb_set;
  logic                in_reset;

  assign in_reset = (rst == RST_ENABLE);

  // Latency requests below the minimum are stretched to the minimum
  always_comb begin
    eff_len = (id_mc_len_i < MIN_LEN) ? MIN_LEN : id_mc_len_i;
  end

  // A new multi-cycle op may enter execute from idle or on the final cycle
  // of the previous one, provided decode is hazard-free and nothing flushes
  always_comb begin
    issue_window = (state_q == PHC_IDLE) || (state_q == PHC_LAST);
    issue        = id_valid_i & id_mc_i & ~hazard & ~flush_i & issue_window;
    sb_set       = issue & id_wreg_i & (id_wd_i != '0);
  end

  mc_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (sb_set),
    .set_addr (id_wd_i),
    .clr_en   (wb_wreg_i),
    .clr_addr (wb_wd_i),
    .clr_all  (flush_i),
    .rd1_en   (id_reg1_read_i),
    .rd1_addr (id_reg1_addr_i),
    .rd2_en   (id_reg2_read_i),
    .rd2_addr (id_reg2_addr_i),
    .wr_en    (id_wreg_i),
    .wr_addr  (id_wd_i),
    .hazard   (hazard),
    .busy     (sb_busy_o)
  );

  // Multi-cycle sequencer: EXEC counts down the remaining ex cycles, LAST is
  // the single completion cycle and may immediately accept the next op
  always_ff @(posedge clk) begin
    if (in_reset) begin
      state_q   <= PHC_IDLE;
      count_q   <= '0;
      ex_done_q <= 1'b0;
    end else if (flush_i) begin
      state_q   <= PHC_IDLE;
      count_q   <= '0;
      ex_done_q <= 1'b0;
    end else begin
      case (state_q)
        PHC_IDLE: begin
          ex_done_q <= 1'b0;
          if (issue) begin
            state_q <= PHC_EXEC;
            count_q <= eff_len - ONE;
          end
        end
        PHC_EXEC: begin
          count_q <= count_q - ONE;
          if (count_q == ONE) begin
            state_q   <= PHC_LAST;
            ex_done_q <= 1'b1;
          end
        end
        PHC_LAST: begin
          ex_done_q <= 1'b0;
          if (issue) begin
            state_q <= PHC_EXEC;
            count_q <= eff_len - ONE;
          end else begin
            state_q <= PHC_IDLE;
            count_q <= '0;
          end
        end
        default: begin
          state_q   <= PHC_IDLE;
          count_q   <= '0;
          ex_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Stall priority: reset, then flush, then an occupied execute, then hazard
  always_comb begin
    stall_o = STALL_NONE;
    if (in_reset || flush_i) begin
      stall_o = STALL_NONE;
    end else if (state_q == PHC_EXEC) begin
      stall_o = STALL_EX;
    end else if (hazard) begin
      stall_o = STALL_ID;
    end
  end

  // Completion and flush strobes are silenced while reset is asserted
  always_comb begin
    ex_done_o = ex_done_q & ~in_reset;
    flush_o   = flush_i & ~in_reset;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl. The reference model tracks how many
// execute cycles the current multi-cycle op still owns and a plain array of
// pending destination registers, and derives every output from those.

module tb_pipe_hazard_ctrl;

  localparam int NUM_REGS = 32;
  localparam int MC_LEN_W = 4;
  localparam int CYCLES   = 4000;

  logic                clk = 1'b0;
  logic                rst;
  logic                id_valid_i;
  logic                id_reg1_read_i;
  logic [4:0]          id_reg1_addr_i;
  logic                id_reg2_read_i;
  logic [4:0]          id_reg2_addr_i;
  logic                id_wreg_i;
  logic [4:0]          id_wd_i;
  logic                id_mc_i;
  logic [MC_LEN_W-1:0] id_mc_len_i;
  logic                wb_wreg_i;
  logic [4:0]          wb_wd_i;
  logic                flush_i;
  logic [5:0]          stall_o;
  logic                ex_done_o;
  logic                flush_o;
  logic [NUM_REGS-1:0] sb_busy_o;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model state
  int modelExLeft;
  bit modelBusy [NUM_REGS];
  bit busyKnown;

  pipe_hazard_ctrl #(
    .NUM_REGS (NUM_REGS),
    .MC_LEN_W (MC_LEN_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid_i     (id_valid_i),
    .id_reg1_read_i (id_reg1_read_i),
    .id_reg1_addr_i (id_reg1_addr_i),
    .id_reg2_read_i (id_reg2_read_i),
    .id_reg2_addr_i (id_reg2_addr_i),
    .id_wreg_i      (id_wreg_i),
    .id_wd_i        (id_wd_i),
    .id_mc_i        (id_mc_i),
    .id_mc_len_i    (id_mc_len_i),
    .wb_wreg_i      (wb_wreg_i),
    .wb_wd_i        (wb_wd_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .ex_done_o      (ex_done_o),
    .flush_o        (flush_o),
    .sb_busy_o      (sb_busy_o)
  );

  always #5 clk = ~clk;

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Random inputs over a small register window so that hazards and
  // same-cycle set/clear collisions happen often
  task automatic applyStimulus(input bit forceRst);
    rst            = forceRst | ($urandom_range(0, 249) == 0);
    id_valid_i     = ($urandom_range(0, 9) < 8);
    id_reg1_read_i = 1'($urandom_range(0, 1));
    id_reg1_addr_i = 5'($urandom_range(0, 7));
    id_reg2_read_i = 1'($urandom_range(0, 1));
    id_reg2_addr_i = 5'($urandom_range(0, 7));
    id_wreg_i      = ($urandom_range(0, 9) < 7);
    id_wd_i        = 5'($urandom_range(0, 7));
    id_mc_i        = ($urandom_range(0, 9) < 4);
    if ($urandom_range(0, 9) < 2) begin
      id_mc_len_i = 4'($urandom_range(0, 15));
    end else begin
      id_mc_len_i = 4'($urandom_range(0, 5));
    end
    wb_wreg_i = ($urandom_range(0, 9) < 4);
    wb_wd_i   = 5'($urandom_range(0, 7));
    flush_i   = ($urandom_range(0, 49) == 0);
  endtask

  // A register blocks decode if it has a pending result not retiring now
  function automatic bit pendingNow(input int r);
    if (r == 0) return 1'b0;
    if (wb_wreg_i && (int'(wb_wd_i) == r)) return 1'b0;
    return modelBusy[r];
  endfunction

  function automatic bit modelHazard();
    return (id_reg1_read_i && pendingNow(int'(id_reg1_addr_i))) ||
           (id_reg2_read_i && pendingNow(int'(id_reg2_addr_i))) ||
           (id_wreg_i      && pendingNow(int'(id_wd_i)));
  endfunction

  initial begin
    logic [5:0]          expStall;
    logic                expDone;
    logic                expFlush;
    logic [NUM_REGS-1:0] expBusy;
    bit                  hz;
    bit                  doIssue;
    int                  effLen;

    rst            = 1'b1;
    id_valid_i     = 1'b0;
    id_reg1_read_i = 1'b0;
    id_reg1_addr_i = '0;
    id_reg2_read_i = 1'b0;
    id_reg2_addr_i = '0;
    id_wreg_i      = 1'b0;
    id_wd_i        = '0;
    id_mc_i        = 1'b0;
    id_mc_len_i    = '0;
    wb_wreg_i      = 1'b0;
    wb_wd_i        = '0;
    flush_i        = 1'b0;
    modelExLeft    = 0;
    busyKnown      = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) modelBusy[r] = 1'b0;

    for (int c = 0; c < CYCLES; c++) begin
      @(negedge clk);
      applyStimulus(c < 2);
      #1;

      hz       = modelHazard();
      expStall = 6'b000000;
      if (!rst && !flush_i) begin
        if (modelExLeft >= 2) expStall = 6'b001111;
        else if (hz)          expStall = 6'b000111;
      end
      expDone  = !rst && (modelExLeft == 1);
      expFlush = flush_i && !rst;
      for (int r = 0; r < NUM_REGS; r++) expBusy[r] = modelBusy[r];

      checkOutput("stall_o", 32'(stall_o), 32'(expStall));
      checkOutput("ex_done_o", 32'(ex_done_o), 32'(expDone));
      checkOutput("flush_o", 32'(flush_o), 32'(expFlush));
      if (busyKnown) begin
        checkOutput("sb_busy_o", sb_busy_o, expBusy);
      end

      doIssue = id_valid_i && id_mc_i && !hz && !flush_i && (modelExLeft <= 1);
      effLen  = (int'(id_mc_len_i) < 2) ? 2 : int'(id_mc_len_i);

      @(posedge clk);
      if (rst || flush_i) begin
        modelExLeft = 0;
        for (int r = 0; r < NUM_REGS; r++) modelBusy[r] = 1'b0;
        if (rst) busyKnown = 1'b1;
      end else begin
        if (wb_wreg_i) modelBusy[int'(wb_wd_i)] = 1'b0;
        if (doIssue && id_wreg_i && (id_wd_i != 5'd0)) modelBusy[int'(id_wd_i)] = 1'b1;
        if (doIssue)               modelExLeft = effLen;
        else if (modelExLeft > 0)  modelExLeft = modelExLeft - 1;
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
